// File: rtl/pe_feeder.sv
// pe_feeder: streams source vectors into the edge of a systolic PE array.
//
// A job is requested with a start pulse in IDLE. The feeder clears the PE
// accumulators for one cycle (pe_en low), streams k_len vectors (inserting
// all-zero bubbles on stall cycles), drains the skew pipeline, then pulses
// done for one cycle.
//
// Build option: define PE_FEEDER_SKEW_EN to delay lane i by i+1 cycles
// (systolic skew) and drain with LANES-1 flush cycles. Without it every lane
// has a latency of one cycle and FLUSH is skipped.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      job request, only honoured in IDLE
//   k_len      vectors per job, latched on an accepted start
//   s_valid    source vector valid
//   s_ready    feeder accepts a vector this cycle (only in STREAM)
//   s_data     source vector, lane i in bits [i*DW +: DW]
//   lane_data  per-lane operand to the PE edge, same packing
//   lane_done  per-lane last-element flag, travels with its lane data
//   pe_en      PE enable, low only in CLEAR and reset
//   busy       job active (CLEAR, STREAM, FLUSH, FIN)
//   done       one-cycle job-complete pulse, the cycle after FIN
module pe_feeder #(
    parameter int LANES = 4,
    parameter int DW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            k_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [LANES*DW-1:0]   s_data,
    output logic [LANES*DW-1:0]   lane_data,
    output logic [LANES-1:0]      lane_done,
    output logic                  pe_en,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]          state;
    logic [2:0]          next_state;
    logic [7:0]          remaining;
    logic                handshake;
    logic                last_hs;
    logic [LANES*DW-1:0] entry_data;
    logic                entry_done;

    // s_ready is registered and high exactly while in STREAM
    assign handshake = s_valid & s_ready;
    assign last_hs   = handshake & (remaining == 8'd1);

`ifdef PE_FEEDER_SKEW_EN
    localparam int FW = $clog2(LANES);
    logic [FW-1:0] flush_cnt;

    // Flush counter: counts FLUSH cycles, held at zero elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state == S_FLUSH) begin
            flush_cnt <= flush_cnt + {{(FW-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt <= '0;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_CLEAR;
                else       next_state = S_IDLE;
            end
            S_CLEAR: begin
                if (remaining != 8'd0) next_state = S_STREAM;
                else                   next_state = S_FIN;
            end
            S_STREAM: begin
`ifdef PE_FEEDER_SKEW_EN
                if (last_hs) next_state = S_FLUSH;
`else
                if (last_hs) next_state = S_FIN;
`endif
                else         next_state = S_STREAM;
            end
            S_FLUSH: begin
`ifdef PE_FEEDER_SKEW_EN
                // LANES-1 flush cycles lets the last lane's data emerge in FIN
                if (flush_cnt == FW'(LANES - 2)) next_state = S_FIN;
                else                             next_state = S_FLUSH;
`else
                next_state = S_FIN;
`endif
            end
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Lane entry: vector on handshake, otherwise an all-zero bubble
    always_comb begin
        entry_data = '0;
        entry_done = 1'b0;
        if (handshake) begin
            entry_data = s_data;
            entry_done = last_hs;
        end else begin
            entry_data = '0;
            entry_done = 1'b0;
        end
    end

    // FSM state, job length counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= 8'd0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            pe_en     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && start) begin
                remaining <= k_len;
            end else if (handshake) begin
                remaining <= remaining - 8'd1;
            end
            s_ready <= (next_state == S_STREAM);
            busy    <= (next_state != S_IDLE);
            pe_en   <= (next_state != S_CLEAR);
            done    <= (state == S_FIN);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef PE_FEEDER_SKEW_EN
        // Lane i is a chain of i+1 stages; data and done flag shift together
        logic [i:0][DW-1:0] sr_data;
        logic [i:0]         sr_done;

        // Skew shift register for lane i
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr_data <= '0;
                sr_done <= '0;
            end else begin
                sr_data[0] <= entry_data[i*DW +: DW];
                sr_done[0] <= entry_done;
                for (int j = 1; j <= i; j++) begin
                    sr_data[j] <= sr_data[j-1];
                    sr_done[j] <= sr_done[j-1];
                end
            end
        end

        assign lane_data[i*DW +: DW] = sr_data[i];
        assign lane_done[i]          = sr_done[i];
`else
        logic [DW-1:0] st_data;
        logic          st_done;

        // Single aligned stage for lane i
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_data <= '0;
                st_done <= 1'b0;
            end else begin
                st_data <= entry_data[i*DW +: DW];
                st_done <= entry_done;
            end
        end

        assign lane_data[i*DW +: DW] = st_data;
        assign lane_done[i]          = st_done;
`endif
    end

endmodule

// File: tb/tb_pe_feeder.sv
module tb_pe_feeder;

    localparam int LANES = 4;
    localparam int DW    = 16;
`ifdef PE_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic [7:0]          k_len;
    logic                s_valid;
    logic                s_ready;
    logic [LANES*DW-1:0] s_data;
    logic [LANES*DW-1:0] lane_data;
    logic [LANES-1:0]    lane_done;
    logic                pe_en;
    logic                busy;
    logic                done;

    pe_feeder #(.LANES(LANES), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .lane_data(lane_data), .lane_done(lane_done),
        .pe_en(pe_en), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          dn;
    } ev_t;

    ev_t lq[LANES][$];   // expected nonzero lane outputs, per lane
    int  dq[$];          // expected done-pulse cycles

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    // Monitor: any lane showing data or a done flag, and any done pulse,
    // must match the oldest expectation for it.
    ev_t           ev;
    logic [DW-1:0] mon_d;
    int            exp_c;
    always @(negedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            mon_d = lane_data[i*DW +: DW];
            if (mon_d != '0 || lane_done[i]) begin
                if (lq[i].size() == 0) begin
                    check(1'b0, $sformatf("lane%0d_unexpected", i), {48'd0, mon_d}, 64'd0);
                end else begin
                    ev = lq[i].pop_front();
                    check(ev.cyc == cyc, $sformatf("lane%0d_cycle", i), 64'(cyc), 64'(ev.cyc));
                    check(ev.d == mon_d, $sformatf("lane%0d_data", i), {48'd0, mon_d}, {48'd0, ev.d});
                    check(ev.dn == lane_done[i], $sformatf("lane%0d_done", i), {63'd0, lane_done[i]}, {63'd0, ev.dn});
                end
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                check(1'b0, "done_unexpected", 64'd1, 64'd0);
            end else begin
                exp_c = dq.pop_front();
                check(exp_c == cyc, "done_cycle", 64'(cyc), 64'(exp_c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*DW-1:0] rand_vec();
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom_range(1, 65535));
        return v;
    endfunction

    // Queue the model's expectations for one accepted vector
    task automatic expect_vec(input logic [LANES*DW-1:0] v, input bit last);
        ev_t e;
        for (int i = 0; i < LANES; i++) begin
            e.cyc = SKEW ? cyc + i + 1 : cyc + 1;
            e.d   = v[i*DW +: DW];
            e.dn  = last;
            lq[i].push_back(e);
        end
    endtask

    // mode 0: always valid; 1: valid then two idle cycles; 2: random valid.
    // abort_after >= 0 resets the DUT after that many vectors.
    task automatic run_job(input int k, input int mode, input int abort_after);
        int  c0, n, s, last_cyc, done_cyc;
        bit  v;
        logic [LANES*DW-1:0] vec;
        start = 1'b1;
        k_len = 8'(k);
        c0    = cyc;
        tick();
        start = 1'b0;
        k_len = 8'($urandom_range(0, 255));   // must not affect the running job
        check(pe_en == 1'b0, "clear_pe_en", {63'd0, pe_en}, 64'd0);
        check(busy == 1'b1, "clear_busy", {63'd0, busy}, 64'd1);
        check(s_ready == 1'b0, "clear_s_ready", {63'd0, s_ready}, 64'd0);
        tick();
        n = 0;
        s = 0;
        last_cyc = c0 + 1;
        while (n < k) begin
            if (abort_after >= 0 && n == abort_after) begin
                #1;
                rst = 1'b1;
                for (int i = 0; i < LANES; i++) lq[i].delete();
                dq.delete();
                s_valid = 1'b0;
                #1;
                check(lane_data == '0, "rst_lane_data", lane_data, 64'd0);
                check(lane_done == '0, "rst_lane_done", {60'd0, lane_done}, 64'd0);
                check({busy, s_ready, pe_en, done} == 4'b0000, "rst_status",
                      {60'd0, busy, s_ready, pe_en, done}, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                repeat (LANES + 4) tick();
                check(busy == 1'b0, "rst_idle_busy", {63'd0, busy}, 64'd0);
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (s % 3 == 0);
                default: v = ($urandom_range(0, 9) < 6);
            endcase
            vec     = rand_vec();
            s_valid = v;
            s_data  = vec;
            start   = ($urandom_range(0, 3) == 0);   // ignored outside IDLE
            check(s_ready == 1'b1, "stream_s_ready", {63'd0, s_ready}, 64'd1);
            if (v) begin
                expect_vec(vec, n == k - 1);
                n++;
                last_cyc = cyc;
            end
            s++;
            tick();
        end
        s_valid = 1'b0;
        start   = 1'b0;
        s_data  = rand_vec();
        if (k == 0) done_cyc = c0 + 3;
        else        done_cyc = last_cyc + (SKEW ? LANES : 1) + 1;
        dq.push_back(done_cyc);
        check(s_ready == 1'b0, "post_stream_s_ready", {63'd0, s_ready}, 64'd0);
        while (cyc < done_cyc + 1) tick();
        check(busy == 1'b0, "idle_busy", {63'd0, busy}, 64'd0);
        check(pe_en == 1'b1, "idle_pe_en", {63'd0, pe_en}, 64'd1);
        check(dq.size() == 0, "done_seen", 64'(dq.size()), 64'd0);
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        k_len   = 8'd0;
        s_valid = 1'b0;
        s_data  = '0;
        #3;
        check(lane_data == '0, "reset_lane_data", lane_data, 64'd0);
        check({busy, s_ready, pe_en, done, lane_done} == 8'd0, "reset_status",
              {56'd0, busy, s_ready, pe_en, done, lane_done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check(pe_en == 1'b1, "idle_after_reset_pe_en", {63'd0, pe_en}, 64'd1);

        run_job(3, 0, -1);    // back-to-back vectors
        run_job(2, 1, -1);    // bubbles between vectors
        run_job(0, 0, -1);    // empty job
        run_job(1, 0, -1);
        run_job(6, 0, 3);     // reset mid-stream
        run_job(4, 0, -1);    // fresh job after reset
        for (int j = 0; j < 8; j++) run_job($urandom_range(1, 10), 2, -1);

        repeat (LANES + 2) tick();
        for (int i = 0; i < LANES; i++)
            check(lq[i].size() == 0, $sformatf("lane%0d_drained", i), 64'(lq[i].size()), 64'd0);
        check(lane_data == '0, "final_lane_data", lane_data, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of systolic lanes driven (range 2..16).
REQ-002 SHALL have parameter DW, default 16, meaning per-lane data width, fix_8_8 unsigned.
REQ-003 SHALL have port clk  input  1  meaning single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  meaning job request pulse, sampled only in IDLE.
REQ-006 SHALL have port k_len  input  8  meaning vectors per job, latched when start is accepted.
REQ-007 SHALL have port s_valid  input  1  meaning source vector valid.
REQ-008 SHALL have port s_ready  output  1  meaning feeder accepts a vector this cycle.
REQ-009 SHALL have port s_data  input  LANES*DW  meaning source vector, lane i in bits [i*DW +: DW].
REQ-010 SHALL have port lane_data  output  LANES*DW  meaning per-lane operand to PE edge, same packing.
REQ-011 SHALL have port lane_done  output  LANES  meaning per-lane last-element flag, driven into PE input_done.
REQ-012 SHALL have port pe_en  output  1  meaning PE enable; low clears PE accumulators.
REQ-013 SHALL have ports busy  output  1 and done  output  1  meaning job active, one-cycle job-complete pulse.

Function
REQ-014 SHALL implement states IDLE, CLEAR, STREAM, FLUSH, FIN.
REQ-015 IDLE: start=1 -> CLEAR, latch k_len; start in any other state SHALL be ignored.
REQ-016 CLEAR: lasts exactly 1 cycle with pe_en=0, then STREAM if latched k_len>0, else FIN.
REQ-017 STREAM: s_ready=1; handshake = s_valid & s_ready; each handshake pushes s_data into lane entry stage and decrements remaining count.
REQ-018 STREAM cycle without handshake SHALL push an all-zero bubble with done flag 0 (zero product keeps PE sums correct).
REQ-019 Handshake of the k_len-th vector SHALL set its done flag=1 and move to FLUSH next cycle; s_ready SHALL be 0 outside STREAM.
REQ-020 Skew: lane i output SHALL equal lane i entry delayed i+1 cycles (lane 0 latency 1, lane LANES-1 latency LANES); lane_done[i] SHALL travel with lane i data.
REQ-021 FLUSH: pushes zero bubbles for exactly LANES-1 cycles, then FIN.
REQ-022 FIN: 1 cycle, done=1, then IDLE; lane_done[LANES-1] SHALL have been high in the FIN-entry cycle.
REQ-023 pe_en SHALL be 1 in every state except CLEAR and reset; it stays 1 in IDLE so PE sums hold for readout.
REQ-024 busy SHALL be 1 in CLEAR, STREAM, FLUSH, FIN; 0 in IDLE.
REQ-025 In IDLE all skew stages SHALL shift zeros; lane_data and lane_done SHALL be 0 once drained.
REQ-026 No arithmetic on data; only counters: 8-bit remaining count, flush counter of clog2(LANES) bits, no wrap permitted.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, all skew stages 0, lane_data=0, lane_done=0, pe_en=0, s_ready=0, busy=0, done=0, counters 0.
REQ-028 rst mid-job SHALL abandon the job with no done pulse; first start after rst release begins a fresh job.

Configuration
REQ-029 Macro PE_FEEDER_SKEW_EN defined: skew per REQ-020 and FLUSH per REQ-021.
REQ-030 PE_FEEDER_SKEW_EN undefined: all lanes latency 1 (broadcast-aligned), FLUSH skipped (STREAM -> FIN directly), ports unchanged.

Verification
REQ-031 LANES=4, k_len=3, s_valid always 1, vectors V0..V2 -> lane 0 shows V0..V2 cycles 1..3 after first handshake, lane 3 cycles 4..6; lane_done[3] with V2; done 1 cycle later.
REQ-032 k_len=2, s_valid low 2 cycles between vectors -> two all-zero bubbles on each lane at skewed positions; lane_done only with V1.
REQ-033 k_len=0 -> CLEAR 1 cycle (pe_en=0), FIN 1 cycle, done=1, no nonzero lane_data.
REQ-034 start asserted during STREAM -> ignored; single done per job; k_len change mid-job has no effect.
REQ-035 rst pulsed mid-STREAM -> all outputs 0 same cycle, no done; new start then completes normally.
REQ-036 Build without PE_FEEDER_SKEW_EN, k_len=2 -> all lanes show V0,V1 on the same cycles; done 1 cycle after lane_done.
